// File: rtl/key_event_decoder.sv
// rtl/key_event_decoder.sv - debounced key level to press/release/long-press/repeat strobes
// Optional auto-repeat is enabled by defining KEY_EVENT_DECODER_REPEAT_EN.
module key_event_decoder #(
  parameter int KEY_ACTIVE_HIGH = 1,
  parameter int LONG_PRESS_CYC  = 1000,
  parameter int REPEAT_CYC      = 200
) (
  input  logic clk_i,
  input  logic s_rst_i,
  input  logic key_state_i,
  output logic press_stb_o,
  output logic release_stb_o,
  output logic long_press_stb_o,
  output logic repeat_stb_o,
  output logic key_held_o
);

  localparam int MAX_CYC = (LONG_PRESS_CYC > REPEAT_CYC) ? LONG_PRESS_CYC : REPEAT_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYC - 1);
  localparam logic             ACT_LVL   = (KEY_ACTIVE_HIGH != 0);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HELD = 2'd1;
  localparam logic [1:0] ST_LONG = 2'd2;

  if (LONG_PRESS_CYC < 2) begin : g_bad_long
    $error("key_event_decoder: LONG_PRESS_CYC must be >= 2");
  end
  if (REPEAT_CYC < 1) begin : g_bad_repeat
    $error("key_event_decoder: REPEAT_CYC must be >= 1");
  end

  logic             key_act;
  logic             key_act_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_d, release_d, long_d;

  assign key_act = key_state_i ^ ~ACT_LVL;

`ifdef KEY_EVENT_DECODER_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYC - 1);
  logic repeat_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
`ifdef KEY_EVENT_DECODER_REPEAT_EN
    repeat_d  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (key_act && !key_act_q) begin
          press_d = 1'b1;
          state_d = ST_HELD;
        end
      end
      ST_HELD: begin
        // Release is checked first so it wins over a coincident threshold hit.
        if (!key_act) begin
          release_d = 1'b1;
          state_d   = ST_IDLE;
          cnt_d     = '0;
        end else if (cnt_q == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = ST_LONG;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_LONG: begin
        if (!key_act) begin
          release_d = 1'b1;
          state_d   = ST_IDLE;
          cnt_d     = '0;
        end else begin
`ifdef KEY_EVENT_DECODER_REPEAT_EN
          if (cnt_q == REP_LAST) begin
            repeat_d = 1'b1;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`else
          cnt_d = '0;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (s_rst_i) begin
      state_q          <= ST_IDLE;
      cnt_q            <= '0;
      key_act_q        <= 1'b0;
      press_stb_o      <= 1'b0;
      release_stb_o    <= 1'b0;
      long_press_stb_o <= 1'b0;
      key_held_o       <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      key_act_q        <= key_act;
      press_stb_o      <= press_d;
      release_stb_o    <= release_d;
      long_press_stb_o <= long_d;
      key_held_o       <= (state_d != ST_IDLE);
    end
  end

`ifdef KEY_EVENT_DECODER_REPEAT_EN
  always_ff @(posedge clk_i) begin
    if (s_rst_i) begin
      repeat_stb_o <= 1'b0;
    end else begin
      repeat_stb_o <= repeat_d;
    end
  end
`else
  assign repeat_stb_o = 1'b0;
`endif

endmodule

// File: tb/tb_key_event_decoder.sv
// tb/tb_key_event_decoder.sv - directed vector bench for key_event_decoder
// Runs an active-high and an active-low instance side by side on the same logical key.
module tb_key_event_decoder;

  localparam logic [4:0] P = 5'b10000;
  localparam logic [4:0] R = 5'b01000;
  localparam logic [4:0] L = 5'b00100;
  localparam logic [4:0] T = 5'b00010;
  localparam logic [4:0] H = 5'b00001;
  localparam logic [4:0] Z = 5'b00000;

`ifdef KEY_EVENT_DECODER_REPEAT_EN
  localparam logic [4:0] REP_MASK = 5'b11111;
`else
  localparam logic [4:0] REP_MASK = 5'b11101;
`endif

  typedef struct {
    bit         rst;
    bit         key;
    logic [4:0] exp;
  } vec_t;

  logic clk;
  logic rst;
  logic key;
  logic key_n;
  logic press_a, release_a, long_a, rpt_a, held_a;
  logic press_b, release_b, long_b, rpt_b, held_b;

  int n_cmp;
  int n_bad;
  vec_t vecs[$];

  assign key_n = ~key;

  key_event_decoder #(
    .KEY_ACTIVE_HIGH(1),
    .LONG_PRESS_CYC (10),
    .REPEAT_CYC     (4)
  ) dut_a (
    .clk_i           (clk),
    .s_rst_i         (rst),
    .key_state_i     (key),
    .press_stb_o     (press_a),
    .release_stb_o   (release_a),
    .long_press_stb_o(long_a),
    .repeat_stb_o    (rpt_a),
    .key_held_o      (held_a)
  );

  key_event_decoder #(
    .KEY_ACTIVE_HIGH(0),
    .LONG_PRESS_CYC (10),
    .REPEAT_CYC     (4)
  ) dut_b (
    .clk_i           (clk),
    .s_rst_i         (rst),
    .key_state_i     (key_n),
    .press_stb_o     (press_b),
    .release_stb_o   (release_b),
    .long_press_stb_o(long_b),
    .repeat_stb_o    (rpt_b),
    .key_held_o      (held_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input bit r, input bit k, input logic [4:0] e, input int n);
    for (int i = 0; i < n; i++) vecs.push_back('{rst: r, key: k, exp: e});
  endtask

  task automatic apply(input bit r, input bit k, input logic [4:0] e, input string name, input int idx);
    logic [4:0] got_a;
    logic [4:0] got_b;
    logic [4:0] want;
    @(negedge clk);
    rst = r;
    key = k;
    @(posedge clk);
    #1;
    want  = e & REP_MASK;
    got_a = {press_a, release_a, long_a, rpt_a, held_a};
    got_b = {press_b, release_b, long_b, rpt_b, held_b};
    n_cmp++;
    if (got_a !== want) begin
      n_bad++;
      $display("FAIL %s[%0d] active_high {press,rel,long,rpt,held}: got %b want %b", name, idx, got_a, want);
    end
    n_cmp++;
    if (got_b !== want) begin
      n_bad++;
      $display("FAIL %s[%0d] active_low {press,rel,long,rpt,held}: got %b want %b", name, idx, got_b, want);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    key   = 1'b0;

    // Reset, then idle
    add(1, 0, Z, 3);
    add(0, 0, Z, 50);
    // Short press: 5 active cycles
    add(0, 1, P | H, 1);
    add(0, 1, H, 4);
    add(0, 0, R, 1);
    add(0, 0, Z, 3);
    // Minimum-width pulse
    add(0, 1, P | H, 1);
    add(0, 0, R, 1);
    add(0, 0, Z, 2);
    // Long press with repeats: 25 active cycles
    add(0, 1, P | H, 1);
    add(0, 1, H, 9);
    add(0, 1, L | H, 1);
    add(0, 1, H, 3);
    add(0, 1, T | H, 1);
    add(0, 1, H, 3);
    add(0, 1, T | H, 1);
    add(0, 1, H, 3);
    add(0, 1, T | H, 1);
    add(0, 1, H, 2);
    add(0, 0, R, 1);
    add(0, 0, Z, 2);
    // Boundary: release sampled at the long-press threshold edge
    add(0, 1, P | H, 1);
    add(0, 1, H, 9);
    add(0, 0, R, 1);
    add(0, 0, Z, 2);
    // 30-cycle hold
    add(0, 1, P | H, 1);
    add(0, 1, H, 9);
    add(0, 1, L | H, 1);
    for (int j = 0; j < 4; j++) begin
      add(0, 1, H, 3);
      add(0, 1, T | H, 1);
    end
    add(0, 1, H, 3);
    add(0, 0, R, 1);
    add(0, 0, Z, 2);
    // Reset mid-hold in LONG with key still active
    add(0, 1, P | H, 1);
    add(0, 1, H, 9);
    add(0, 1, L | H, 1);
    add(0, 1, H, 2);
    add(1, 1, Z, 2);
    add(0, 1, P | H, 1);
    add(0, 1, H, 2);
    add(0, 0, R, 1);
    add(0, 0, Z, 2);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].rst, vecs[i].key, vecs[i].exp, "table", i);
    end

    // Release coinciding with the first repeat threshold: release only
    apply(0, 1, P | H, "rel_at_rpt", 0);
    for (int i = 1; i < 10; i++) apply(0, 1, H, "rel_at_rpt", i);
    apply(0, 1, L | H, "rel_at_rpt", 10);
    for (int i = 11; i < 14; i++) apply(0, 1, H, "rel_at_rpt", i);
    apply(0, 0, R, "rel_at_rpt", 14);
    apply(0, 0, Z, "rel_at_rpt", 15);

    // Counter restarts from 0 after a release: a new hold needs a full 10 cycles
    apply(0, 1, P | H, "rehold", 0);
    for (int i = 1; i < 10; i++) apply(0, 1, H, "rehold", i);
    apply(0, 1, L | H, "rehold", 10);
    apply(0, 0, R, "rehold", 11);
    apply(0, 0, Z, "rehold", 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/key_event_decoder.md
Name: key_event_decoder

Overview:
- Sits directly downstream of the key debouncer and consumes its debounced, already-synchronised key level.
- Converts the level into single-cycle event strobes: press, release, long-press and, optionally, auto-repeat.
- Also provides a held-level output for UI/control logic.
- All timing is counted in clk_i cycles. No asynchronous inputs are allowed; the input must already be debounced.

Parameters:
- KEY_ACTIVE_HIGH, 1: polarity of key_state_i. 1 means a 1 is "pressed"; 0 means a 0 is "pressed".
- LONG_PRESS_CYC, 1000: hold duration in cycles before long_press_stb_o fires. Must be >= 2.
- REPEAT_CYC, 200: auto-repeat period in cycles after a long press. Must be >= 1.
- CNT_W, $clog2(max(LONG_PRESS_CYC, REPEAT_CYC)) + 1: hold counter width. Derived; not to be overridden.

Ports:
- clk_i  in  1  system clock, the same domain as the debouncer.
- s_rst_i  in  1  synchronous reset, active-high.
- key_state_i  in  1  debounced key level from the debouncer.
- press_stb_o  out  1  one-cycle strobe on the inactive->active transition.
- release_stb_o  out  1  one-cycle strobe on the active->inactive transition.
- long_press_stb_o  out  1  one-cycle strobe when a hold reaches LONG_PRESS_CYC.
- repeat_stb_o  out  1  one-cycle strobe every REPEAT_CYC while in long hold.
- key_held_o  out  1  level; 1 while the FSM is in HELD or LONG.

Behaviour:
- Input normalisation: key_act = key_state_i XOR ~KEY_ACTIVE_HIGH.
- Reset: FSM goes to IDLE, hold counter to 0, key_act_q to 0 (inactive). All outputs are 0.
  - A key already active when reset releases produces press_stb_o on the first post-reset sample.
- All outputs are registered. A strobe is high for exactly one cycle, in the cycle after the clock edge that detects the event.
- FSM states: IDLE, HELD, LONG.
- IDLE:
  - On an edge sampling key_act=1: pulse press_stb_o, go to HELD, set cnt=0.
- HELD:
  - On an edge with key_act=1: if cnt == LONG_PRESS_CYC-1, pulse long_press_stb_o, go to LONG, set cnt=0. Otherwise cnt++.
  - On an edge with key_act=0: pulse release_stb_o, go to IDLE, set cnt=0.
- LONG:
  - On an edge with key_act=1 and repeat enabled: if cnt == REPEAT_CYC-1, pulse repeat_stb_o and wrap cnt to 0. Otherwise cnt++.
  - On an edge with key_act=0: pulse release_stb_o, go to IDLE, set cnt=0.
- Timing, key held continuously from the press:
  - long_press_stb_o is high exactly LONG_PRESS_CYC cycles after press_stb_o.
  - The first repeat_stb_o is REPEAT_CYC cycles after long_press_stb_o, then every REPEAT_CYC cycles.
- Simultaneous events:
  - Release at the same edge as a threshold hit: release wins. No long/repeat strobe is generated in that cycle.
  - At most one strobe output is high in any cycle.
- Minimum-width pulses:
  - A 1-cycle active pulse produces press_stb_o and then release_stb_o in consecutive cycles, with no long press.
- key_held_o:
  - Rises in the same cycle as press_stb_o.
  - Falls in the same cycle as release_stb_o.
- Counter:
  - Never exceeds max(LONG_PRESS_CYC, REPEAT_CYC)-1.
  - No free-running wrap: in IDLE it holds at 0.
- Reset mid-hold:
  - Return to IDLE without release_stb_o.
  - If the key is still active after reset, a fresh press_stb_o follows on the next sample.
- Elaboration error if LONG_PRESS_CYC < 2 or REPEAT_CYC < 1.

Optional Feature:
- Macro: KEY_EVENT_DECODER_REPEAT_EN.
- Defined: the LONG-state repeat counting and repeat_stb_o behave as specified above.
- Not defined:
  - repeat_stb_o is tied to 0.
  - In LONG the counter holds at 0 and the FSM stays in LONG until release.
  - No repeat logic is synthesised. The port remains present so the interface is unchanged.

Test Plan:
- Reset then idle: s_rst_i=1 for 3 cycles, key inactive for 50 cycles -> all outputs 0 throughout.
- Short press, with LONG_PRESS_CYC=10: key active for 5 cycles ->
  - press_stb_o once, key_held_o high for 5 cycles, release_stb_o once.
  - No long_press_stb_o.
- Long press with repeat, with LONG_PRESS_CYC=10, REPEAT_CYC=4 and the macro defined: key held for 25 cycles ->
  - press at cycle t, long at t+10, repeats at t+14, t+18, t+22.
  - release at t+25.
- Boundary release: key held exactly 10 cycles (release sampled at the threshold edge) -> release_stb_o only, no long_press_stb_o.
- Polarity and macro off, with KEY_ACTIVE_HIGH=0 and the macro undefined:
  - key_state_i low for 30 cycles -> press, then long at +10.
  - No repeat_stb_o ever; release when the input returns high.
- Reset mid-hold: assert s_rst_i in LONG while the key stays active ->
  - No release_stb_o.
  - press_stb_o one cycle after reset deasserts.
